// File: rtl/timer_ctrl.sv
// timer_ctrl -- prescaled match timer controlling an external 8-bit counter.
//
// A start request latches a match value (cmp), a prescale divisor minus one
// (psc) and a one-shot/periodic mode, clears the external counter for one
// cycle and then issues a count-enable pulse every psc+1 unpaused cycles
// until the counter reaches the match value. One-shot runs park in DONE,
// periodic runs go straight back through CLEAR. Every match produces a
// one-cycle registered done pulse and bumps a saturating period count.
//
// Ports:
//   clk       in   single clock, rising edge
//   clr       in   synchronous active-high reset
//   start     in   begin timing (accepted in IDLE/DONE with cmp != 0)
//   stop      in   abort to IDLE from any non-IDLE state
//   pause     in   level, freezes prescaler and count enables
//   periodic  in   auto-restart after match, sampled with start
//   cmp       in   [7:0] match value, sampled with start
//   psc       in   [PS_W-1:0] prescale divisor minus one, sampled with start
//   cnt_out   in   [7:0] current value of the controlled counter
//   irq_ack   in   interrupt acknowledge
//   cnt_en    out  one-cycle count-enable pulse to the counter
//   cnt_clr   out  counter clear request
//   busy      out  high in CLEAR and RUN
//   done      out  registered one-cycle pulse per match
//   periods   out  [7:0] completed-match count, saturating at 255
//   irq       out  sticky interrupt, set by done, cleared by irq_ack
//
// Configuration macro: TIMER_CTRL_IRQ_EN. When undefined, irq is tied low
// and irq_ack has no effect.

module timer_ctrl #(
  parameter int PS_W = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            stop,
  input  logic            pause,
  input  logic            periodic,
  input  logic [7:0]      cmp,
  input  logic [PS_W-1:0] psc,
  input  logic [7:0]      cnt_out,
  input  logic            irq_ack,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            busy,
  output logic            done,
  output logic [7:0]      periods,
  output logic            irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PS_W-1:0] pc;
  logic [PS_W-1:0] psc_q;
  logic [7:0]      cmp_q;
  logic            periodic_q;

  logic            abort;
  logic            launch;
  logic            hit;

  // stop outranks start, so a stop in DONE also suppresses a relaunch, and
  // a stop on the match cycle swallows the done pulse.
  always_comb begin
    abort     = (state != IDLE) && stop;
    launch    = ((state == IDLE) || (state == DONE)) && start &&
                (cmp != 8'd0) && !abort;
    hit       = (state == RUN) && (cnt_out == cmp_q) && !abort;
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (launch) state_nxt = CLEAR;
        CLEAR:   state_nxt = RUN;
        RUN:     if (hit) state_nxt = periodic_q ? CLEAR : DONE;
        DONE:    if (launch) state_nxt = CLEAR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state == CLEAR) || (state == RUN);
    cnt_clr = clr || (state == CLEAR) || abort;
    cnt_en  = !clr && (state == RUN) && !pause && (pc == psc_q) &&
              (cnt_out != cmp_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Prescaler restarts from zero on every pass through CLEAR so that each
  // period is measured from a clean phase.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc <= '0;
    end else if (state == CLEAR) begin
      pc <= '0;
    end else if ((state == RUN) && !pause) begin
      pc <= (pc == psc_q) ? '0 : pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cmp_q      <= 8'd0;
      psc_q      <= '0;
      periodic_q <= 1'b0;
    end else if (launch) begin
      cmp_q      <= cmp;
      psc_q      <= psc;
      periodic_q <= periodic;
    end
  end

  // periods moves on the same edge that raises done, so it already shows the
  // new count during the done cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      done    <= 1'b0;
      periods <= 8'd0;
    end else begin
      done <= hit;
      if (launch) begin
        periods <= 8'd0;
      end else if (hit && (periods != 8'hFF)) begin
        periods <= periods + 8'd1;
      end
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  // Set has priority over acknowledge so a pulse landing on an ack is kept.
  always_ff @(posedge clk) begin
    if (clr) begin
      irq <= 1'b0;
    end else if (done) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`else
  // irq_ack is folded in only so the input stays consumed; irq is always 0.
  assign irq = irq_ack & 1'b0;
`endif

endmodule
